serial_uart_bridge: RTL and testbench
=====================================

SERIAL_UART_BRIDGE -- requirements
Module: serial_uart_bridge

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set clocks per UART bit period (legal values >= 4).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set entries in each of the RX and TX FIFOs (legal values are powers of 2, >= 2).
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-high.
REQ-005 ser_data_out  output  8  SHALL be the RX FIFO head byte, driven to the processor's serial_in.
REQ-006 ser_valid_out  output  1  SHALL be high iff the RX FIFO is non-empty; drives the processor's serial_valid_in.
REQ-007 ser_rden_in  input  1  SHALL be the processor's one-cycle pop strobe for the RX FIFO.
REQ-008 ser_ready_out  output  1  SHALL be high iff the TX FIFO is not full; drives the processor's serial_ready_in.
REQ-009 ser_data_in  input  8  SHALL be the processor's byte to transmit.
REQ-010 ser_wren_in  input  1  SHALL be the processor's one-cycle push strobe for the TX FIFO.
REQ-011 uart_rx  input  1  SHALL be the asynchronous UART line, 8N1, LSB first, idle high.
REQ-012 uart_tx  output  1  SHALL be the UART line, 8N1, LSB first, idle high, registered.
REQ-013 frame_err  output  1  SHALL be a sticky flag: a received stop bit sampled low.
REQ-014 overrun  output  1  SHALL be a sticky flag: a received byte was dropped because the RX FIFO was full.

Function
REQ-015 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-016 RX FSM states IDLE, START, DATA, STOP: IDLE->START on synced low; START samples at CLKS_PER_BIT/2, returns to IDLE if high (glitch), else ->DATA; DATA samples 8 bits each CLKS_PER_BIT apart; STOP samples once more, then ->IDLE.
REQ-017 Stop sampled high SHALL push the byte into the RX FIFO on that edge; stop sampled low SHALL discard the byte and set frame_err.
REQ-018 A push to a full RX FIFO SHALL drop the new byte, leave contents unchanged, and set overrun.
REQ-019 ser_rden_in with RX FIFO empty SHALL be ignored; ser_data_out SHALL read 8'h00 whenever ser_valid_out is 0.
REQ-020 Simultaneous RX push and ser_rden_in pop on a non-empty FIFO SHALL both take effect; count unchanged, order preserved.
REQ-021 ser_wren_in with TX FIFO not full SHALL push ser_data_in that edge; with TX FIFO full it SHALL be dropped silently.
REQ-022 TX FSM states IDLE, START, DATA, STOP: in IDLE with registered TX count > 0, it SHALL pop the head into a shift register and enter START on the same edge.
REQ-023 uart_tx SHALL be 0 for CLKS_PER_BIT clocks in START, then data LSB first for CLKS_PER_BIT clocks each, then 1 for CLKS_PER_BIT clocks in STOP, then return to IDLE (back-to-back frames allowed with no gap).
REQ-024 Latency: with TX idle and the FIFO empty, a byte pushed at edge N SHALL be popped at edge N+1, with uart_tx low from edge N+2 onward.
REQ-025 A simultaneous TX push and pop SHALL both take effect; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-026 While reset is high, on each edge: both FIFOs empty, both FSMs in IDLE, bit/baud counters 0, synchronizer flops 1, uart_tx=1, frame_err=0, overrun=0.
REQ-027 Consequently, after reset ser_valid_out=0, ser_data_out=8'h00, ser_ready_out=1.
REQ-028 Reset asserted mid-frame SHALL abort that frame immediately (uart_tx=1 after the edge); no partial RX byte SHALL be pushed.
REQ-029 frame_err and overrun SHALL clear only on reset.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-030 Single ser_wren_in pulse with 0x55 -> uart_tx low 16 clk; then 1,0,1,0,1,0,1,0 at 16 clk each; then high 16 clk; total 160 clk.
REQ-031 Drive a valid 0xA3 frame on uart_rx -> ser_valid_out=1 with ser_data_out=0xA3 after stop sample; one ser_rden_in pulse -> ser_valid_out=0, ser_data_out=0x00.
REQ-032 ser_wren_in on 6 consecutive cycles, bytes 0x01..0x06, TX idle -> 0x01 popped the next cycle; FIFO full after 0x05; ser_ready_out=0; 0x06 dropped; uart_tx emits 0x01..0x05 in order.
REQ-033 Frame 0x7E with stop bit low -> no RX push, ser_valid_out stays 0, frame_err=1 and remains 1 until reset.
REQ-034 5 valid frames 0x10..0x14 with no ser_rden_in -> overrun=1; 4 pops return 0x10..0x13, then ser_valid_out=0.
REQ-035 reset pulse during DATA bit 3 of a TX frame and mid-RX frame -> uart_tx=1 next cycle, ser_valid_out=0, ser_ready_out=1, no byte later appears.

Source files
------------

// File: rtl/serial_uart_bridge_if.sv
// Processor-side byte handshake between the CPU and the UART bridge.
// The master drives push/pop strobes and the byte to transmit. The slave returns the RX head and the flow-control flags.
interface serial_uart_bridge_if;
    logic [7:0] ser_data_out;
    logic       ser_valid_out;
    logic       ser_rden_in;
    logic       ser_ready_out;
    logic [7:0] ser_data_in;
    logic       ser_wren_in;

    modport master (
        input  ser_data_out, ser_valid_out, ser_ready_out,
        output ser_rden_in, ser_data_in, ser_wren_in
    );

    modport slave (
        output ser_data_out, ser_valid_out, ser_ready_out,
        input  ser_rden_in, ser_data_in, ser_wren_in
    );
endinterface

// File: rtl/serial_uart_bridge.sv
// 8N1 UART bridge with an RX FIFO and a TX FIFO in front of a byte-wide processor handshake.
// The RX line is synchronized and sampled mid-bit. The TX line is registered and sends frames back to back.
module serial_uart_bridge #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_uart_bridge_if.slave  ser,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    output logic                 frame_err,
    output logic                 overrun
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [PTR_W:0]   LVL_ONE   = 1;
    localparam logic [PTR_W:0]   DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);

    logic rx_meta, rx_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    uart_state_e      rx_state, rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_tick, rx_push, rx_ferr;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        rx_next = rx_state;
        rx_tick = 1'b0;
        rx_push = 1'b0;
        rx_ferr = 1'b0;
        case (rx_state)
            IDLE:  if (!rx_sync) rx_next = START;
            START: if (rx_cnt == HALF_LAST) begin
                       rx_tick = 1'b1;
                       rx_next = rx_sync ? IDLE : DATA;
                   end
            DATA:  if (rx_cnt == BIT_LAST) begin
                       rx_tick = 1'b1;
                       if (rx_bit == 3'd7) rx_next = STOP;
                   end
            STOP:  if (rx_cnt == BIT_LAST) begin
                       rx_tick = 1'b1;
                       rx_next = IDLE;
                       rx_push = rx_sync;
                       rx_ferr = !rx_sync;
                   end
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= (rx_state == IDLE || rx_tick) ? '0 : rx_cnt + CNT_ONE;
            if (rx_state == DATA && rx_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr, rx_rd;
    logic [PTR_W:0]   rx_count;
    logic             rx_full, rx_empty, rx_do_push, rx_do_pop;

    assign rx_full    = (rx_count == DEPTH);
    assign rx_empty   = (rx_count == '0);
    assign rx_do_push = rx_push && !rx_full;
    assign rx_do_pop  = ser.ser_rden_in && !rx_empty;

    // NOTE: FIFO storage has no reset; the pointers and the count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (rx_do_push) rx_mem[rx_wr] <= rx_shift;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wr     <= '0;
            rx_rd     <= '0;
            rx_count  <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rx_do_push) rx_wr <= rx_wr + PTR_ONE;
            if (rx_do_pop)  rx_rd <= rx_rd + PTR_ONE;
            case ({rx_do_push, rx_do_pop})
                2'b10:   rx_count <= rx_count + LVL_ONE;
                2'b01:   rx_count <= rx_count - LVL_ONE;
                default: rx_count <= rx_count;
            endcase
            if (rx_ferr)            frame_err <= 1'b1;
            if (rx_push && rx_full) overrun   <= 1'b1;
        end
    end

    assign ser.ser_valid_out = !rx_empty;
    assign ser.ser_data_out  = rx_empty ? 8'h00 : rx_mem[rx_rd];

    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr, tx_rd;
    logic [PTR_W:0]   tx_count;
    logic             tx_full, tx_empty, tx_do_push, tx_pop;

    assign tx_full           = (tx_count == DEPTH);
    assign tx_empty          = (tx_count == '0);
    assign tx_do_push        = ser.ser_wren_in && !tx_full;
    assign ser.ser_ready_out = !tx_full;

    always_ff @(posedge clock) begin
        if (tx_do_push) tx_mem[tx_wr] <= ser.ser_data_in;
    end

    uart_state_e      tx_state, tx_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_tick, tx_line;

    // The end of a stop bit may pop the next byte directly, so queued frames leave no idle gap.
    always_comb begin
        tx_next = tx_state;
        tx_tick = 1'b0;
        tx_pop  = 1'b0;
        tx_line = 1'b1;
        case (tx_state)
            IDLE:  if (!tx_empty) begin
                       tx_pop  = 1'b1;
                       tx_next = START;
                   end
            START: begin
                       tx_line = 1'b0;
                       if (tx_cnt == BIT_LAST) begin
                           tx_tick = 1'b1;
                           tx_next = DATA;
                       end
                   end
            DATA:  begin
                       tx_line = tx_shift[0];
                       if (tx_cnt == BIT_LAST) begin
                           tx_tick = 1'b1;
                           if (tx_bit == 3'd7) tx_next = STOP;
                       end
                   end
            STOP:  if (tx_cnt == BIT_LAST) begin
                       tx_tick = 1'b1;
                       tx_pop  = !tx_empty;
                       tx_next = tx_empty ? IDLE : START;
                   end
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state == IDLE || tx_tick) ? '0 : tx_cnt + CNT_ONE;
            uart_tx  <= tx_line;
            if (tx_pop) begin
                tx_shift <= tx_mem[tx_rd];
            end else if (tx_state == DATA && tx_tick) begin
                tx_shift <= {1'b1, tx_shift[7:1]};
            end
            if (tx_state == DATA && tx_tick) tx_bit <= tx_bit + 3'd1;
            if (tx_do_push) tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)     tx_rd <= tx_rd + PTR_ONE;
            case ({tx_do_push, tx_pop})
                2'b10:   tx_count <= tx_count + LVL_ONE;
                2'b01:   tx_count <= tx_count - LVL_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed bench for serial_uart_bridge at CLKS_PER_BIT=16 and FIFO_DEPTH=4.
// Expected values are hand-computed from the frame format and the FIFO depth.
module tb_serial_uart_bridge;
    logic clock;
    logic reset;
    logic uart_rx;
    logic uart_tx;
    logic frame_err;
    logic overrun;

    serial_uart_bridge_if bus ();

    serial_uart_bridge #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .ser       (bus),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) tick();
        end
        uart_rx = stop;
        repeat (16) tick();
        uart_rx = 1'b1;
        repeat (4) tick();
    endtask

    // Waits for the start bit, then checks all 160 line cycles from cycle first_i onward.
    task automatic tx_frame(input string tag, input logic [7:0] b, input int first_i);
        int   n;
        int   bad;
        logic exp;
        n   = 0;
        bad = 0;
        while (uart_tx !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_start"}, uart_tx, 1'b0);
        for (int i = first_i; i < 160; i++) begin
            if (i < 16)       exp = 1'b0;
            else if (i < 144) exp = b[(i - 16) / 16];
            else              exp = 1'b1;
            if (uart_tx !== exp) bad++;
            tick();
        end
        check(tag, bad, 0);
    endtask

    task automatic pop_rx();
        bus.ser_rden_in = 1'b1;
        tick();
        bus.ser_rden_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int quiet;
        reset           = 1'b1;
        uart_rx         = 1'b1;
        bus.ser_rden_in = 1'b0;
        bus.ser_wren_in = 1'b0;
        bus.ser_data_in = 8'h00;
        repeat (3) tick();

        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_valid", bus.ser_valid_out, 1'b0);
        check("rst_data", bus.ser_data_out, 8'h00);
        check("rst_ready", bus.ser_ready_out, 1'b1);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        repeat (2) tick();

        // Single 0x55 push: line stays high one edge, drops on the second.
        bus.ser_data_in = 8'h55;
        bus.ser_wren_in = 1'b1;
        tick();
        bus.ser_wren_in = 1'b0;
        check("tx55_ready_after_push", bus.ser_ready_out, 1'b1);
        tick();
        check("tx55_lat_n1", uart_tx, 1'b1);
        tick();
        check("tx55_lat_n2", uart_tx, 1'b0);
        tx_frame("tx55", 8'h55, 0);
        check("tx55_idle_after", uart_tx, 1'b1);
        repeat (5) tick();

        // Six pushes: byte 0x01 is popped after one edge, the FIFO fills with 0x02..0x05, and 0x06 is dropped.
        for (int k = 1; k <= 6; k++) begin
            bus.ser_data_in = 8'(k);
            bus.ser_wren_in = 1'b1;
            tick();
            check($sformatf("tx_fill_ready_%0d", k), bus.ser_ready_out, (k >= 5) ? 1'b0 : 1'b1);
        end
        bus.ser_wren_in = 1'b0;
        tx_frame("tx_q01", 8'h01, 3);
        tx_frame("tx_q02", 8'h02, 0);
        check("tx_ready_reopened", bus.ser_ready_out, 1'b1);
        tx_frame("tx_q03", 8'h03, 0);
        tx_frame("tx_q04", 8'h04, 0);
        tx_frame("tx_q05", 8'h05, 0);
        quiet = 0;
        for (int i = 0; i < 200; i++) begin
            if (uart_tx !== 1'b1) quiet++;
            tick();
        end
        check("tx_06_dropped", quiet, 0);

        // Valid RX frame 0xA3, then a pop, then a pop on the empty FIFO.
        send_rx(8'hA3, 1'b1);
        check("rx_a3_valid", bus.ser_valid_out, 1'b1);
        check("rx_a3_data", bus.ser_data_out, 8'hA3);
        check("rx_a3_no_ferr", frame_err, 1'b0);
        pop_rx();
        check("rx_a3_popped_valid", bus.ser_valid_out, 1'b0);
        check("rx_a3_popped_data", bus.ser_data_out, 8'h00);
        pop_rx();
        check("rx_empty_pop_valid", bus.ser_valid_out, 1'b0);

        // 0x7E with a low stop bit: the byte is discarded and frame_err is set.
        send_rx(8'h7E, 1'b0);
        repeat (20) tick();
        check("rx_7e_valid", bus.ser_valid_out, 1'b0);
        check("rx_7e_frame_err", frame_err, 1'b1);

        // Five frames with no pops: four are stored, the fifth sets overrun.
        for (int k = 0; k < 4; k++) send_rx(8'h10 + 8'(k), 1'b1);
        check("ovr_before_fifth", overrun, 1'b0);
        send_rx(8'h14, 1'b1);
        check("ovr_after_fifth", overrun, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovr_pop_%0d", k), bus.ser_data_out, 32'h10 + k);
            pop_rx();
        end
        check("ovr_drained_valid", bus.ser_valid_out, 1'b0);
        check("ferr_still_set", frame_err, 1'b1);
        check("ovr_still_set", overrun, 1'b1);

        // Reset during TX data bit 3 of 0xF0 (a low bit) and during an RX frame of 0xF8.
        fork
            send_rx(8'hF8, 1'b1);
            begin
                bus.ser_data_in = 8'hF0;
                bus.ser_wren_in = 1'b1;
                tick();
                bus.ser_wren_in = 1'b0;
                repeat (71) tick();
                check("mid_tx_bit3_low", uart_tx, 1'b0);
                reset = 1'b1;
                tick();
                check("mid_rst_uart_tx", uart_tx, 1'b1);
                check("mid_rst_valid", bus.ser_valid_out, 1'b0);
                check("mid_rst_ready", bus.ser_ready_out, 1'b1);
                check("mid_rst_ferr", frame_err, 1'b0);
                check("mid_rst_ovr", overrun, 1'b0);
                reset = 1'b0;
            end
        join
        quiet = 0;
        for (int i = 0; i < 200; i++) begin
            if (uart_tx !== 1'b1 || bus.ser_valid_out !== 1'b0) quiet++;
            tick();
        end
        check("post_rst_quiet", quiet, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
